// File: rtl/axi_lite_intr_ctrl_slave.sv
// AXI4-Lite interrupt controller: GIE/IER/ISR/IAR/IPR register file, sticky source capture, one irq line.
// Latency: ISR->irq 1 cycle, source edge->irq 2 cycles; AXI write/read response one cycle after handshake.
// Backpressure: one outstanding write and one outstanding read; no new AW/W or AR accepted until B/R completes.
// Optional feature macro: INTR_SOFT_SET_EN (0x14 ISS write-1-to-set; unmapped when undefined).
module axi_lite_intr_ctrl_slave #(
  parameter int                       C_S_AXI_DATA_WIDTH  = 32,
  parameter int                       C_S_AXI_ADDR_WIDTH  = 5,
  parameter int                       C_NUM_OF_INTR       = 1,
  parameter logic [C_NUM_OF_INTR-1:0] C_INTR_SENSITIVITY  = '1,
  parameter logic [C_NUM_OF_INTR-1:0] C_INTR_ACTIVE_STATE = '1,
  parameter bit                       C_IRQ_ACTIVE_STATE  = 1'b1
) (
  input  logic                            S_AXI_INTR_ACLK,
  input  logic                            S_AXI_INTR_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_INTR_AWADDR,
  input  logic [2:0]                      S_AXI_INTR_AWPROT,
  input  logic                            S_AXI_INTR_AWVALID,
  output logic                            S_AXI_INTR_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_INTR_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_INTR_WSTRB,
  input  logic                            S_AXI_INTR_WVALID,
  output logic                            S_AXI_INTR_WREADY,
  output logic [1:0]                      S_AXI_INTR_BRESP,
  output logic                            S_AXI_INTR_BVALID,
  input  logic                            S_AXI_INTR_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_INTR_ARADDR,
  input  logic [2:0]                      S_AXI_INTR_ARPROT,
  input  logic                            S_AXI_INTR_ARVALID,
  output logic                            S_AXI_INTR_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_INTR_RDATA,
  output logic [1:0]                      S_AXI_INTR_RRESP,
  output logic                            S_AXI_INTR_RVALID,
  input  logic                            S_AXI_INTR_RREADY,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  output logic                            irq
);

  localparam int N  = C_NUM_OF_INTR;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  localparam logic [2:0] ADDR_GIE = 3'd0;
  localparam logic [2:0] ADDR_IER = 3'd1;
  localparam logic [2:0] ADDR_ISR = 3'd2;
  localparam logic [2:0] ADDR_IAR = 3'd3;
  localparam logic [2:0] ADDR_IPR = 3'd4;
  localparam logic [2:0] ADDR_ISS = 3'd5;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;
  logic            awready_q, awready_d;
  logic            arready_q, arready_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            gie_q, gie_d;
  logic [N-1:0]    ier_q, ier_d;
  logic [N-1:0]    isr_q, isr_d;
  logic [N-1:0]    prev_src_q, prev_src_d;
  logic            irq_q, irq_d;

  logic            wr_fire, rd_fire;
  logic [2:0]      wr_sel, rd_sel;
  logic [DW-1:0]   wr_bits, strb_mask;
  logic [N-1:0]    ack_mask, soft_mask, hw_set;
  logic [N-1:0]    src_act, prev_act;
  logic [DW-1:0]   ier_w, isr_w, ipr_w, rd_word;

  assign wr_fire = awready_q && S_AXI_INTR_AWVALID && S_AXI_INTR_WVALID && (w_state_q == W_IDLE);
  assign rd_fire = arready_q && S_AXI_INTR_ARVALID && (r_state_q == R_IDLE);
  assign wr_sel  = S_AXI_INTR_AWADDR[4:2];
  assign rd_sel  = S_AXI_INTR_ARADDR[4:2];

  // Byte-strobe masking of write data; only enabled bytes can set, clear or ack bits
  always_comb begin
    wr_bits   = '0;
    strb_mask = '0;
    for (int b = 0; b < DW/8; b++) begin
      strb_mask[8*b +: 8] = {8{S_AXI_INTR_WSTRB[b]}};
      wr_bits[8*b +: 8]   = S_AXI_INTR_WDATA[8*b +: 8] & {8{S_AXI_INTR_WSTRB[b]}};
    end
  end

  // Register write decode: GIE/IER updates plus ack and software-set masks for this cycle
  always_comb begin
    gie_d     = gie_q;
    ier_d     = ier_q;
    ack_mask  = '0;
    soft_mask = '0;
    if (wr_fire) begin
      case (wr_sel)
        ADDR_GIE: if (S_AXI_INTR_WSTRB[0]) gie_d = S_AXI_INTR_WDATA[0];
        ADDR_IER: ier_d = (ier_q & ~strb_mask[N-1:0]) | wr_bits[N-1:0];
        ADDR_IAR: ack_mask = wr_bits[N-1:0];
`ifdef INTR_SOFT_SET_EN
        ADDR_ISS: soft_mask = wr_bits[N-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Source capture in normalised (1 = active) form; set always beats ack in the same cycle
  always_comb begin
    src_act    = ~(intr_src ^ C_INTR_ACTIVE_STATE);
    prev_act   = ~(prev_src_q ^ C_INTR_ACTIVE_STATE);
    hw_set     = (C_INTR_SENSITIVITY & src_act & ~prev_act) | (~C_INTR_SENSITIVITY & src_act);
    prev_src_d = intr_src;
    isr_d      = (isr_q & ~ack_mask) | hw_set | soft_mask;
    irq_d      = (gie_q && (|(isr_q & ier_q))) ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE;
  end

  // Read mux; bits above the source count read as zero
  always_comb begin
    ier_w          = '0;
    isr_w          = '0;
    ipr_w          = '0;
    ier_w[N-1:0]   = ier_q;
    isr_w[N-1:0]   = isr_q;
    ipr_w[N-1:0]   = isr_q & ier_q;
    rd_word        = '0;
    case (rd_sel)
      ADDR_GIE: rd_word[0] = gie_q;
      ADDR_IER: rd_word = ier_w;
      ADDR_ISR: rd_word = isr_w;
      ADDR_IPR: rd_word = ipr_w;
      default:  rd_word = '0;
    endcase
  end

  // Write channel FSM: registered AW/W ready pulse, then hold B until accepted
  always_comb begin
    w_state_d = w_state_q;
    awready_d = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (wr_fire) begin
          w_state_d = W_RESP;
        end else if (S_AXI_INTR_AWVALID && S_AXI_INTR_WVALID && !awready_q) begin
          awready_d = 1'b1;
        end
      end
      W_RESP: if (S_AXI_INTR_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel FSM: registered AR ready pulse, data captured at handshake and held until accepted
  always_comb begin
    r_state_d = r_state_q;
    arready_d = 1'b0;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_fire) begin
          r_state_d = R_DATA;
          rdata_d   = rd_word;
        end else if (S_AXI_INTR_ARVALID && !arready_q) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: if (S_AXI_INTR_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Register file, capture and irq state
  always_ff @(posedge S_AXI_INTR_ACLK) begin
    if (S_AXI_INTR_ARESET) begin
      gie_q      <= 1'b0;
      ier_q      <= '0;
      isr_q      <= '0;
      prev_src_q <= ~C_INTR_ACTIVE_STATE;
      irq_q      <= ~C_IRQ_ACTIVE_STATE;
    end else begin
      gie_q      <= gie_d;
      ier_q      <= ier_d;
      isr_q      <= isr_d;
      prev_src_q <= prev_src_d;
      irq_q      <= irq_d;
    end
  end

  // AXI channel state; reset drops any pending B/R beat
  always_ff @(posedge S_AXI_INTR_ACLK) begin
    if (S_AXI_INTR_ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_INTR_AWREADY = awready_q;
  assign S_AXI_INTR_WREADY  = awready_q;
  assign S_AXI_INTR_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_INTR_BRESP   = 2'b00;
  assign S_AXI_INTR_ARREADY = arready_q;
  assign S_AXI_INTR_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_INTR_RDATA   = rdata_q;
  assign S_AXI_INTR_RRESP   = 2'b00;
  assign irq                = irq_q;

  // Protection bits, byte-offset address bits and data bits above the source count carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{S_AXI_INTR_AWPROT, S_AXI_INTR_ARPROT, S_AXI_INTR_AWADDR,
                       S_AXI_INTR_ARADDR, wr_bits, strb_mask};

endmodule

// File: tb/tb_axi_lite_intr_ctrl_slave.sv
// Directed bench for the AXI4-Lite interrupt controller with 4 sources:
// bit0/bit1 rising edge, bit2 falling edge, bit3 level-high.
module tb_axi_lite_intr_ctrl_slave;

  logic        clk;
  logic        rst;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [3:0]  intr_src;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  axi_lite_intr_ctrl_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .C_NUM_OF_INTR      (4),
    .C_INTR_SENSITIVITY (4'b0111),
    .C_INTR_ACTIVE_STATE(4'b1011),
    .C_IRQ_ACTIVE_STATE (1'b1)
  ) dut (
    .S_AXI_INTR_ACLK   (clk),
    .S_AXI_INTR_ARESET (rst),
    .S_AXI_INTR_AWADDR (awaddr),
    .S_AXI_INTR_AWPROT (awprot),
    .S_AXI_INTR_AWVALID(awvalid),
    .S_AXI_INTR_AWREADY(awready),
    .S_AXI_INTR_WDATA  (wdata),
    .S_AXI_INTR_WSTRB  (wstrb),
    .S_AXI_INTR_WVALID (wvalid),
    .S_AXI_INTR_WREADY (wready),
    .S_AXI_INTR_BRESP  (bresp),
    .S_AXI_INTR_BVALID (bvalid),
    .S_AXI_INTR_BREADY (bready),
    .S_AXI_INTR_ARADDR (araddr),
    .S_AXI_INTR_ARPROT (arprot),
    .S_AXI_INTR_ARVALID(arvalid),
    .S_AXI_INTR_ARREADY(arready),
    .S_AXI_INTR_RDATA  (rdata),
    .S_AXI_INTR_RRESP  (rresp),
    .S_AXI_INTR_RVALID (rvalid),
    .S_AXI_INTR_RREADY (rready),
    .intr_src          (intr_src),
    .irq               (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic axi_write(input logic [4:0] a, input logic [31:0] dat, input logic [3:0] s, input bit pulse0);
    int n;
    awaddr = a; wdata = dat; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!(awready && wready)) begin
      errors++;
      $display("FAIL wr_accept addr=%h: awready=%b wready=%b, required 1 within 20 cycles", a, awready, wready);
    end
    if (pulse0) intr_src[0] = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (pulse0) intr_src[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!bvalid || bresp !== 2'b00) begin
      errors++;
      $display("FAIL wr_resp addr=%h: bvalid=%b bresp=%b, required 1/00", a, bvalid, bresp);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] dat);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!arready) begin
      errors++;
      $display("FAIL rd_accept addr=%h: arready=%b, required 1 within 20 cycles", a, arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!rvalid || rresp !== 2'b00) begin
      errors++;
      $display("FAIL rd_resp addr=%h: rvalid=%b rresp=%b, required 1/00", a, rvalid, rresp);
    end
    dat = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // Toggle one source for exactly one sampled cycle
  task automatic pulse_src(input int idx);
    intr_src[idx] = ~intr_src[idx];
    @(posedge clk); #1;
    intr_src[idx] = ~intr_src[idx];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hs: got %b, required 00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_data: rdata=%h bresp=%b rresp=%b, required 0", rdata, bresp, rresp);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", irq); end
    rst = 1'b0;
    axi_read(5'h00, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_gie: got %h, required 0", d); end
    axi_read(5'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ier: got %h, required 0", d); end
    axi_read(5'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_isr: got %h, required 0", d); end
  endtask

  task automatic test_basic;
    axi_write(5'h00, 32'h1, 4'hF, 1'b0);
    axi_write(5'h04, 32'h1, 4'hF, 1'b0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_idle: got %b, required 0", irq); end
    pulse_src(0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_lat1: got %b, required 0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq_lat2: got %b, required 1", irq); end
    axi_read(5'h10, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL basic_ipr: got %h, required 1", d); end
    axi_read(5'h08, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL basic_isr: got %h, required 1", d); end
  endtask

  task automatic test_ack;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ack_pre_irq: got %b, required 1", irq); end
    axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_irq: got %b, required 0", irq); end
    axi_read(5'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ack_ipr: got %h, required 0", d); end
    axi_read(5'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ack_isr: got %h, required 0", d); end
  endtask

  task automatic test_ier_mask;
    axi_write(5'h04, 32'h0, 4'hF, 1'b0);
    pulse_src(0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq: got %b, required 0", irq); end
    axi_read(5'h08, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL mask_isr: got %h, required 1", d); end
    axi_read(5'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mask_ipr: got %h, required 0", d); end
    axi_write(5'h04, 32'h1, 4'hF, 1'b0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_unmask_irq: got %b, required 1", irq); end
    axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_clr_irq: got %b, required 0", irq); end
  endtask

  task automatic test_ack_vs_edge;
    pulse_src(0);
    @(posedge clk); #1;
    axi_write(5'h0C, 32'h1, 4'hF, 1'b1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq: got %b, required 1", irq); end
    axi_read(5'h08, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL race_isr: got %h, required 1", d); end
    axi_write(5'h0C, 32'h1, 4'hF, 1'b0);
    axi_read(5'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL race_clr_isr: got %h, required 0", d); end
  endtask

  task automatic test_backpressure;
    int n;
    awaddr = 5'h04; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    checks++; if (!awready) begin errors++; $display("FAIL bp_wr_accept: awready=%b, required 1", awready); end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        errors++;
        $display("FAIL bp_b_hold cyc%0d: bvalid=%b awready=%b, required 1/0", i, bvalid, awready);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL bp_b_done: bvalid=%b, required 0", bvalid); end

    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    checks++; if (!arready) begin errors++; $display("FAIL bp_rd_accept: arready=%b, required 1", arready); end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h3 || arready !== 1'b0) begin
        errors++;
        $display("FAIL bp_r_hold cyc%0d: rvalid=%b rdata=%h arready=%b, required 1/3/0", i, rvalid, rdata, arready);
      end
    end
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL bp_r_done: rvalid=%b, required 0", rvalid); end
  endtask

  task automatic test_rw_same_cycle;
    logic [31:0] d_rw;
    fork
      axi_write(5'h04, 32'h5, 4'hF, 1'b0);
      axi_read(5'h04, d_rw);
    join
    checks++; if (d_rw !== 32'h3) begin errors++; $display("FAIL rw_old_value: got %h, required 3", d_rw); end
    axi_read(5'h04, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL rw_new_value: got %h, required 5", d); end
  endtask

  task automatic test_wstrb_map;
    axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, 1'b0);
    axi_read(5'h04, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL ier_width: got %h, required f", d); end
    axi_write(5'h04, 32'h0, 4'b1110, 1'b0);
    axi_read(5'h04, d);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL ier_strb_off: got %h, required f", d); end
    axi_write(5'h04, 32'h0, 4'b0001, 1'b0);
    axi_read(5'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ier_strb_on: got %h, required 0", d); end
    axi_write(5'h00, 32'h0, 4'b1110, 1'b0);
    axi_read(5'h00, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL gie_strb_off: got %h, required 1", d); end
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 1'b0);
    axi_read(5'h18, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h, required 0", d); end
    axi_read(5'h0C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL iar_rd: got %h, required 0", d); end
    axi_write(5'h04, 32'hF, 4'hF, 1'b0);
  endtask

  task automatic test_modes;
    pulse_src(2);
    axi_read(5'h08, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL fall_edge_isr: got %h, required 4", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fall_edge_irq: got %b, required 1", irq); end
    axi_write(5'h0C, 32'h4, 4'hF, 1'b0);
    axi_read(5'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fall_rise_ignored: got %h, required 0", d); end
    intr_src[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    axi_read(5'h08, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL level_isr: got %h, required 8", d); end
    axi_write(5'h0C, 32'h8, 4'hF, 1'b0);
    axi_read(5'h08, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL level_reassert: got %h, required 8", d); end
    intr_src[3] = 1'b0;
    axi_write(5'h0C, 32'h8, 4'hF, 1'b0);
    axi_read(5'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL level_clr: got %h, required 0", d); end
    intr_src[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    axi_read(5'h08, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL edge_held_isr: got %h, required 2", d); end
    axi_write(5'h0C, 32'h2, 4'hF, 1'b0);
    axi_read(5'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_held_once: got %h, required 0", d); end
    intr_src[1] = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL modes_irq_end: got %b, required 0", irq); end
  endtask

  task automatic test_soft_set;
    logic        exp_irq;
    logic [31:0] exp_isr;
`ifdef INTR_SOFT_SET_EN
    exp_irq = 1'b1; exp_isr = 32'h1;
`else
    exp_irq = 1'b0; exp_isr = 32'h0;
`endif
    axi_write(5'h14, 32'h1, 4'hF, 1'b0);
    checks++; if (irq !== exp_irq) begin errors++; $display("FAIL soft_irq: got %b, required %b", irq, exp_irq); end
    axi_read(5'h08, d);
    checks++; if (d !== exp_isr) begin errors++; $display("FAIL soft_isr: got %h, required %h", d, exp_isr); end
    axi_read(5'h14, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL soft_rd: got %h, required 0", d); end
    axi_write(5'h0C, 32'hF, 4'hF, 1'b0);
  endtask

  task automatic test_reset_mid;
    int n;
    awaddr = 5'h04; wdata = 32'hF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 5'h04; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending: bvalid=%b rvalid=%b, required 1/1", bvalid, rvalid);
    end
    intr_src = 4'b0101;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: bvalid=%b rvalid=%b rdata=%h irq=%b, required 0", bvalid, rvalid, rdata, irq);
    end
    rst = 1'b0;
    axi_read(5'h08, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL post_reset_edge: got %h, required 1", d); end
    axi_read(5'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL post_reset_ier: got %h, required 0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b, required 0", irq); end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    intr_src = 4'b0100;
    test_reset();
    test_basic();
    test_ack();
    test_ier_mask();
    test_ack_vs_edge();
    test_backpressure();
    test_rw_same_cycle();
    test_wstrb_map();
    test_modes();
    test_soft_set();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
